// File: rtl/adc_sampler_pkg.sv
// rtl/adc_sampler_pkg.sv - shared constants and types for the adc_sampler block
//
// Purpose: result width and FSM state encoding shared by the top, interface and bench.
// Ports: none (package).

package adc_sampler_pkg;

  localparam int ADC_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    START   = 2'd1,
    CONV    = 2'd2,
    RELEASE = 2'd3
  } sampler_state_t;

endpackage

// File: rtl/adc_sampler_if.sv
// rtl/adc_sampler_if.sv - host/ADC signal bundle for adc_sampler
//
// Purpose: groups the host control, FIFO read side and ADC handshake pins.
// Ports (signals):
//   en, period, single        host trigger controls
//   adc_start, adc_done,
//   adc_data                  ADC macro handshake
//   rd_en, rd_data, empty,
//   full                      result FIFO read side
//   overrun, clr_ovr          sticky drop flag and its clear
//   busy                      sequencer not idle
// Modports: master = host/ADC environment, slave = adc_sampler.

interface adc_sampler_if #(
  parameter int DIV_W = 16
);

  logic                             en;
  logic [DIV_W-1:0]                 period;
  logic                             single;
  logic                             adc_start;
  logic                             adc_done;
  logic [adc_sampler_pkg::ADC_W-1:0] adc_data;
  logic                             rd_en;
  logic [adc_sampler_pkg::ADC_W-1:0] rd_data;
  logic                             empty;
  logic                             full;
  logic                             overrun;
  logic                             clr_ovr;
  logic                             busy;

  modport master (
    output en, period, single, adc_done, adc_data, rd_en, clr_ovr,
    input  adc_start, rd_data, empty, full, overrun, busy
  );

  modport slave (
    input  en, period, single, adc_done, adc_data, rd_en, clr_ovr,
    output adc_start, rd_data, empty, full, overrun, busy
  );

endinterface

// File: rtl/adc_sampler_fifo.sv
// rtl/adc_sampler_fifo.sv - show-ahead result FIFO
//
// Purpose: small synchronous FIFO; the head entry is always visible on rdata_o.
// Ports:
//   clk, rstn       clock, asynchronous active-low reset
//   push_i, wdata_i write request and data (ignored when full unless popping)
//   pop_i           read request (ignored when empty)
//   rdata_o         head entry, 0 while empty
//   full_o, empty_o status flags

module adc_sampler_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             wr_ok, rd_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign rd_ok   = pop_i && !empty_o;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign wr_ok   = push_i && (!full_o || rd_ok);
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Power-of-two depth: pointers wrap by natural overflow.
    if (wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_ok) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/adc_sampler.sv
// rtl/adc_sampler.sv - periodic/one-shot SAR ADC conversion sequencer
//
// Purpose: triggers conversions from a period timer or a single pulse, runs the
// start/done handshake, and buffers results in a show-ahead FIFO.
// Ports:
//   clk   single rising-edge clock
//   rstn  asynchronous active-low reset
//   bus   adc_sampler_if.slave (host controls, ADC pins, FIFO read side, flags)
// Option: ADC_SAMPLER_AVG_EN adds a 2^AVG_LOG2-sample averager ahead of the FIFO.

module adc_sampler
  import adc_sampler_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16,
  parameter int AVG_LOG2   = 2
) (
  input  logic          clk,
  input  logic          rstn,
  adc_sampler_if.slave  bus
);

  sampler_state_t   state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             pend_tmr_q, pend_tmr_d;
  logic             pend_sgl_q, pend_sgl_d;
  logic             ovr_q, ovr_d;

  logic             tmr_fire, pend, consume;
  logic             adc_start, busy, capture;
  logic             push, pop, drop;
  logic [ADC_W-1:0] push_data;
  logic             fifo_full, fifo_empty;

  // Timer: held at period while disabled, so the first trigger comes a full
  // period after enabling; reset leaves it at 0 for an immediate first trigger.
  always_comb begin
    cnt_d    = cnt_q;
    tmr_fire = 1'b0;
    if (!bus.en) begin
      cnt_d = bus.period;
    end else if (cnt_q == '0) begin
      tmr_fire = 1'b1;
      cnt_d    = bus.period;
    end else begin
      cnt_d = cnt_q - DIV_W'(1);
    end
  end

  // Timer and single requests are tracked apart so that disabling the timer
  // cannot swallow a pending one-shot request. A new trigger beats the clear.
  assign pend    = pend_tmr_q || pend_sgl_q;
  assign consume = (state_q == IDLE) && pend;

  always_comb begin
    pend_tmr_d = pend_tmr_q;
    pend_sgl_d = pend_sgl_q;
    if (tmr_fire)                 pend_tmr_d = 1'b1;
    else if (consume || !bus.en)  pend_tmr_d = 1'b0;
    if (bus.single)               pend_sgl_d = 1'b1;
    else if (consume)             pend_sgl_d = 1'b0;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pend) state_d = START;
      START:   state_d = CONV;
      CONV:    if (bus.adc_done) state_d = RELEASE;
      RELEASE: if (!bus.adc_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    adc_start = 1'b0;
    busy      = 1'b1;
    capture   = 1'b0;
    case (state_q)
      IDLE:    busy = 1'b0;
      START:   adc_start = 1'b1;
      CONV: begin
        adc_start = 1'b1;
        capture   = bus.adc_done;
      end
      default: ;
    endcase
  end

`ifdef ADC_SAMPLER_AVG_EN
  localparam int ACC_W = ADC_W + AVG_LOG2;

  logic [ACC_W-1:0]    acc_q, acc_d, acc_sum;
  logic [AVG_LOG2-1:0] avg_cnt_q, avg_cnt_d;

  always_comb begin
    acc_sum   = acc_q + ACC_W'(bus.adc_data);
    acc_d     = acc_q;
    avg_cnt_d = avg_cnt_q;
    push      = 1'b0;
    push_data = '0;
    if (capture) begin
      if (avg_cnt_q == '1) begin
        push      = 1'b1;
        push_data = ADC_W'(acc_sum >> AVG_LOG2);
        acc_d     = '0;
        avg_cnt_d = '0;
      end else begin
        acc_d     = acc_sum;
        avg_cnt_d = avg_cnt_q + AVG_LOG2'(1);
      end
    end else if (!bus.en && (state_q == IDLE)) begin
      // Stopping the timer discards a partial average.
      acc_d     = '0;
      avg_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_q     <= '0;
      avg_cnt_q <= '0;
    end else begin
      acc_q     <= acc_d;
      avg_cnt_q <= avg_cnt_d;
    end
  end
`else
  assign push      = capture;
  assign push_data = bus.adc_data;
`endif

  assign pop   = bus.rd_en && !fifo_empty;
  assign drop  = push && fifo_full && !pop;
  // Set wins over clear in the same cycle.
  assign ovr_d = drop || (ovr_q && !bus.clr_ovr);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q      <= '0;
      pend_tmr_q <= 1'b0;
      pend_sgl_q <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      pend_tmr_q <= pend_tmr_d;
      pend_sgl_q <= pend_sgl_d;
      ovr_q      <= ovr_d;
    end
  end

  adc_sampler_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ADC_W)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (push),
    .wdata_i (push_data),
    .pop_i   (bus.rd_en),
    .rdata_o (bus.rd_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign bus.adc_start = adc_start;
  assign bus.busy      = busy;
  assign bus.empty     = fifo_empty;
  assign bus.full      = fifo_full;
  assign bus.overrun   = ovr_q;

endmodule
